// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Brief    : Shared SoC definitions for the IMEM image loader: state codes,
//            stream magic word and error codes.
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  // Loader state codes (fixed 3-bit encoding, kept stable for legacy tools)
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_MAGIC = 3'd1;
  localparam state_t ST_BASE  = 3'd2;
  localparam state_t ST_LEN   = 3'd3;
  localparam state_t ST_DATA  = 3'd4;
  localparam state_t ST_CSUM  = 3'd5;
  localparam state_t ST_DONE  = 3'd6;
  localparam state_t ST_ERR   = 3'd7;

  // First word of every image stream
  localparam logic [31:0] LOADER_MAGIC = 32'hC0DE_B007;

  // Reason reported on err_code when the loader stops in ERR
  typedef enum logic [1:0] {
    ERR_MAGIC   = 2'd0,
    ERR_RANGE   = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Brief    : Image stream, IMEM write port and status signals of the loader.
//            slave = loader side, master = stream source / IMEM / CPU side.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic        start;
  logic        s_vld;
  logic        s_rdy;
  logic [31:0] s_dat;
  logic        imem_cpu_rstn;
  logic        imem_we;
  logic [31:2] imem_waddr;
  logic [31:0] imem_wdat;
  logic        busy;
  logic        done;
  logic        err;
  err_code_t   err_code;

  modport slave (
    input  start, s_vld, s_dat,
    output s_rdy, imem_cpu_rstn, imem_we, imem_waddr, imem_wdat,
           busy, done, err, err_code
  );

  modport master (
    output start, s_vld, s_dat,
    input  s_rdy, imem_cpu_rstn, imem_we, imem_waddr, imem_wdat,
           busy, done, err, err_code
  );

endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Receives MAGIC/BASE/LEN/data/CSUM image stream, writes the data
//            words into IMEM and holds the CPU in reset until a verified image
//            is in place.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned NUM_WORDS_IMEM = 8192,
  parameter int unsigned GAP_TIMEOUT    = 1_000_000
) (
  input  wire logic        clk,
  input  wire logic        arst,
  imem_loader_if.slave     bus
);

  // Counter width chosen so a count equal to NUM_WORDS_IMEM still fits
  localparam int unsigned c_CNT_W = $clog2(NUM_WORDS_IMEM) + 1;

  state_t               r_state;
  logic [29:0]          r_base;
  logic [c_CNT_W-1:0]   r_len;
  logic [c_CNT_W-1:0]   r_idx;
  logic [31:0]          r_sum;
  logic [31:0]          r_gap;
  logic                 r_done;
  logic                 r_err;
  err_code_t            r_err_code;

  logic                 w_busy;
  logic                 w_acc;
  logic                 w_base_bad;
  logic [32:0]          w_end;
  logic                 w_len_bad;
  logic                 w_last;
  logic                 w_gap_expired;

  // Decode of the current state and the checks applied to the incoming word
  always_comb begin
    w_busy        = (r_state == ST_MAGIC) || (r_state == ST_BASE) ||
                    (r_state == ST_LEN)   || (r_state == ST_DATA) ||
                    (r_state == ST_CSUM);
    w_acc         = bus.s_vld && w_busy;
    w_base_bad    = (bus.s_dat[1:0] != 2'b00) || (bus.s_dat[31:28] != 4'h0);
    // BASE is below 2^28 bytes, so 33 bits hold word address + any LEN
    w_end         = {3'b000, r_base} + {1'b0, bus.s_dat};
    w_len_bad     = (bus.s_dat == 32'd0) || (w_end > 33'(NUM_WORDS_IMEM));
    w_last        = (r_idx == (r_len - 1'b1));
    w_gap_expired = (r_gap == 32'(GAP_TIMEOUT - 1));
  end

  // Loader state machine, address/length capture, running checksum, gap timer
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_sum      <= '0;
      r_gap      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_MAGIC;
    end else if (!w_busy) begin
      // IDLE, DONE, ERR: only a start pulse does anything here
      if (bus.start) begin
        r_state    <= ST_MAGIC;
        r_idx      <= '0;
        r_sum      <= '0;
        r_gap      <= '0;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
        r_err_code <= ERR_MAGIC;
      end
    end else if (w_acc) begin
      // An accepted word always wins over a simultaneous timeout
      r_gap <= '0;
      case (r_state)
        ST_MAGIC: begin
          if (bus.s_dat != LOADER_MAGIC) begin
            r_state    <= ST_ERR;
            r_err      <= 1'b1;
            r_err_code <= ERR_MAGIC;
          end else begin
            r_state <= ST_BASE;
          end
        end
        ST_BASE: begin
          if (w_base_bad) begin
            r_state    <= ST_ERR;
            r_err      <= 1'b1;
            r_err_code <= ERR_RANGE;
          end else begin
            r_base  <= bus.s_dat[31:2];
            r_state <= ST_LEN;
          end
        end
        ST_LEN: begin
          // Range is fully validated here so no partial write ever happens
          if (w_len_bad) begin
            r_state    <= ST_ERR;
            r_err      <= 1'b1;
            r_err_code <= ERR_RANGE;
          end else begin
            r_len   <= bus.s_dat[c_CNT_W-1:0];
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          r_sum <= r_sum + bus.s_dat;
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            r_state <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (bus.s_dat == r_sum) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state    <= ST_ERR;
            r_err      <= 1'b1;
            r_err_code <= ERR_CSUM;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end else if (w_gap_expired) begin
      r_state    <= ST_ERR;
      r_err      <= 1'b1;
      r_err_code <= ERR_TIMEOUT;
    end else begin
      r_gap <= r_gap + 1'b1;
    end
  end

  // Outputs: handshake and IMEM write are combinational so a word is written
  // in the same cycle it is accepted; CPU runs only in IDLE and DONE
  always_comb begin
    bus.s_rdy         = w_busy;
    bus.busy          = w_busy;
    bus.imem_cpu_rstn = (r_state == ST_IDLE) || (r_state == ST_DONE);
    bus.imem_we       = (r_state == ST_DATA) && bus.s_vld;
    bus.imem_waddr    = r_base + 30'(r_idx);
    bus.imem_wdat     = bus.s_dat;
    bus.done          = r_done;
    bus.err           = r_err;
    bus.err_code      = r_err_code;
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Self-checking bench for imem_loader: directed image loads, error
//            cases, gap timeout, asynchronous reset mid-load and randomized
//            streams checked against a stream-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int unsigned NW = 8192;
  localparam int unsigned GT = 40;

  logic clk = 1'b0;
  logic arst;
  imem_loader_if bus();

  imem_loader #(.NUM_WORDS_IMEM(NW), .GAP_TIMEOUT(GT)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] stream_q[$];
  logic [61:0] got_q[$];
  logic [61:0] exp_wr[$];

  // Record every IMEM write the DUT performs
  always @(posedge clk) begin
    if (bus.imem_we === 1'b1) got_q.push_back({bus.imem_waddr, bus.imem_wdat});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: walks the stream word by word and decides how many words
  // the loader consumes, the final outcome and the expected IMEM writes.
  task automatic model(output int used, output bit ok, output logic [1:0] code);
    logic [31:0] base, n, sum;
    exp_wr.delete();
    ok = 1'b0; code = 2'd0; sum = 32'd0;
    used = 1;
    if (stream_q[0] != 32'hC0DE_B007) begin code = 2'd0; return; end
    used = 2; base = stream_q[1];
    if ((base % 4) != 0 || base >= 32'h1000_0000) begin code = 2'd1; return; end
    used = 3; n = stream_q[2];
    if (n == 0 || longint'(base / 4) + longint'(n) > longint'(NW)) begin code = 2'd1; return; end
    for (int i = 0; i < int'(n); i++) begin
      exp_wr.push_back({30'(base / 4 + i), stream_q[3 + i]});
      sum = sum + stream_q[3 + i];
    end
    used = 4 + int'(n);
    if (stream_q[3 + n] == sum) ok = 1'b1;
    else code = 2'd2;
  endtask

  // All driving tasks are entered and left right after a falling edge
  task automatic start_pulse();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input int gap, input bit with_start);
    logic r;
    bit   acc = 1'b0;
    bus.s_vld = 1'b1; bus.s_dat = d; bus.start = with_start;
    for (int k = 0; k < 10 && !acc; k++) begin
      #1 r = bus.s_rdy;
      @(negedge clk);
      acc = (r === 1'b1);
    end
    if (!acc) check("send_rdy", 64'(r), 64'd1);
    bus.s_vld = 1'b0; bus.start = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_wr_count"}, 64'(got_q.size()), 64'(exp_wr.size()));
    for (int i = 0; i < got_q.size() && i < exp_wr.size(); i++)
      check({tag, "_wr"}, 64'(got_q[i]), 64'(exp_wr[i]));
  endtask

  // Full load of stream_q: start, send what the loader should consume, check
  task automatic do_load(input string tag, input int fixed_gap, input bit poke_start);
    int used; bit ok; logic [1:0] code; int g;
    model(used, ok, code);
    got_q.delete();
    start_pulse();
    for (int i = 0; i < used; i++) begin
      g = (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(0, 3));
      send(stream_q[i], (i == used - 1) ? 0 : g, poke_start && (i == 1));
    end
    repeat (3) @(negedge clk);
    check({tag, "_done"}, 64'(bus.done), 64'(ok));
    check({tag, "_err"},  64'(bus.err),  64'(!ok));
    check({tag, "_code"}, 64'(bus.err_code), 64'(ok ? 2'd0 : code));
    check({tag, "_rstn"}, 64'(bus.imem_cpu_rstn), 64'(ok));
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    compare_writes(tag);
  endtask

  task automatic build(input logic [31:0] base, input int n, input int csum_delta);
    logic [31:0] sum = 32'd0;
    logic [31:0] d;
    stream_q.delete();
    stream_q.push_back(32'hC0DE_B007);
    stream_q.push_back(base);
    stream_q.push_back(32'(n));
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      stream_q.push_back(d);
      sum = sum + d;
    end
    stream_q.push_back(sum + 32'(csum_delta));
  endtask

  initial begin
    logic [31:0] b;
    int n, kind;
    arst = 1'b1; bus.start = 1'b0; bus.s_vld = 1'b0; bus.s_dat = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_rdy",  64'(bus.s_rdy), 64'd0);
    check("rst_rstn", 64'(bus.imem_cpu_rstn), 64'd1);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err",  64'(bus.err), 64'd0);
    check("rst_code", 64'(bus.err_code), 64'd0);
    check("rst_we",   64'(bus.imem_we), 64'd0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);

    // Basic 3-word image at byte 0x100
    stream_q = '{32'hC0DE_B007, 32'h100, 32'd3, 32'd1, 32'd2, 32'd3, 32'd6};
    do_load("basic", -1, 1'b0);
    if (got_q.size() == 3) begin
      check("basic_addr0", 64'(got_q[0][61:32]), 64'h40);
      check("basic_addr2", 64'(got_q[2][61:32]), 64'h42);
      check("basic_dat2",  64'(got_q[2][31:0]),  64'd3);
    end

    // Wrong magic
    stream_q = '{32'hDEAD_BEEF, 32'h100, 32'd1, 32'd5, 32'd5};
    do_load("magic", -1, 1'b0);

    // Image running one word past the end of IMEM, then exactly fitting
    build(32'h7FFC, 2, 0); do_load("over",  -1, 1'b0);
    build(32'h7FF8, 2, 0); do_load("fit",   -1, 1'b0);
    build(32'h0102, 2, 0); do_load("align", -1, 1'b0);
    build(32'h1000_0000, 1, 0); do_load("high", -1, 1'b0);
    build(32'h0200, 0, 0); do_load("zero",  -1, 1'b0);
    build(32'h0400, 4, 1); do_load("csum",  -1, 1'b0);

    // Start pulses during a load must be ignored; maximal tolerated gaps
    build(32'h0800, 3, 0); do_load("ignst", -1, 1'b1);
    build(32'h0C00, 2, 0); do_load("slow", int'(GT) - 1, 1'b0);

    // Stall mid-DATA until the gap timer fires, then recover
    got_q.delete();
    start_pulse();
    send(32'hC0DE_B007, 0, 1'b0);
    send(32'h200, 0, 1'b0);
    send(32'd3, 0, 1'b0);
    send(32'hAA, int'(GT) + 2, 1'b0);
    check("to_err",  64'(bus.err), 64'd1);
    check("to_code", 64'(bus.err_code), 64'(ERR_TIMEOUT));
    check("to_rstn", 64'(bus.imem_cpu_rstn), 64'd0);
    check("to_busy", 64'(bus.busy), 64'd0);
    check("to_wr",   64'(got_q.size()), 64'd1);
    build(32'h200, 3, 0); do_load("after_to", -1, 1'b0);

    // Asynchronous reset after two data writes
    got_q.delete();
    start_pulse();
    send(32'hC0DE_B007, 0, 1'b0);
    send(32'h100, 0, 1'b0);
    send(32'd4, 0, 1'b0);
    send(32'h11, 0, 1'b0);
    send(32'h22, 0, 1'b0);
    bus.s_vld = 1'b1; bus.s_dat = 32'h33;
    #2 arst = 1'b1;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_rstn", 64'(bus.imem_cpu_rstn), 64'd1);
    check("arst_we",   64'(bus.imem_we), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    arst = 1'b0;
    repeat (3) @(negedge clk);
    bus.s_vld = 1'b0;
    check("arst_wr", 64'(got_q.size()), 64'd2);
    @(negedge clk);

    // Randomized streams, some of them corrupted
    for (int it = 0; it < 30; it++) begin
      n    = int'($urandom_range(1, 6));
      kind = int'($urandom_range(0, 7));
      b    = 32'($urandom_range(0, NW - n)) << 2;
      case (kind)
        0: begin build(b, n, 0); stream_q[0] = stream_q[0] ^ (32'd1 << $urandom_range(0, 31)); end
        1: build(b, n, int'($urandom_range(1, 100)));
        2: build(b | 32'($urandom_range(1, 3)), n, 0);
        3: build(32'(NW - n + 1) << 2, n, 0);
        4: build(b | (32'($urandom_range(1, 15)) << 28), n, 0);
        default: build(b, n, 0);
      endcase
      do_load("rand", -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog in case a wait loop misbehaves
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
